// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the register-file ALU: datapath width, register count,
// opcode encodings and flag bit positions within the 5-bit flag word {C,L,F,Z,N}.
package regfile_alu_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int FLAG_W = 5;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_ADDU = 5'h01;
  localparam logic [4:0] OP_ADDC = 5'h02;
  localparam logic [4:0] OP_SUB  = 5'h03;
  localparam logic [4:0] OP_CMP  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_XOR  = 5'h07;
  localparam logic [4:0] OP_NOT  = 5'h08;
  localparam logic [4:0] OP_LSH  = 5'h09;
  localparam logic [4:0] OP_RSH  = 5'h0A;
  localparam logic [4:0] OP_ARSH = 5'h0B;
  localparam logic [4:0] OP_MOV  = 5'h0C;
  localparam logic [4:0] OP_LUI  = 5'h0D;
  localparam logic [4:0] OP_NOP  = 5'h1F;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/regfile_alu_alu_core.sv
// Purely combinational two-operand ALU: produces the result, whether it is
// written back, the candidate flag values and which flag bits they replace.
module alu_core
  import regfile_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        op_code,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              wr_en,
  output logic [FLAG_W-1:0] flags_next,
  output logic [FLAG_W-1:0] flags_mask
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              add_cin;
  logic              add_ovf;
  logic              sub_ovf;
  logic [3:0]        shamt;

  assign add_cin = (op_code == OP_ADDC) ? c_in : 1'b0;
  assign sum     = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, add_cin};
  assign diff    = a - b;
  // Signed overflow: operands agree (add) or differ (sub) in sign and the result sign flips.
  assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
  assign shamt   = b[3:0];

  always_comb begin
    result     = '0;
    wr_en      = 1'b0;
    flags_next = '0;
    flags_mask = '0;
    case (op_code)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        result             = sum[DATA_W-1:0];
        wr_en              = 1'b1;
        flags_next[FLAG_C] = sum[DATA_W];
        flags_next[FLAG_F] = add_ovf;
        flags_mask[FLAG_C] = 1'b1;
        flags_mask[FLAG_F] = (op_code != OP_ADDU);
      end
      OP_SUB: begin
        result             = diff;
        wr_en              = 1'b1;
        flags_next[FLAG_C] = (a < b);
        flags_next[FLAG_F] = sub_ovf;
        flags_mask[FLAG_C] = 1'b1;
        flags_mask[FLAG_F] = 1'b1;
      end
      OP_CMP: begin
        flags_next[FLAG_Z] = (a == b);
        flags_next[FLAG_L] = (a < b);
        flags_next[FLAG_N] = ($signed(a) < $signed(b));
        flags_mask[FLAG_Z] = 1'b1;
        flags_mask[FLAG_L] = 1'b1;
        flags_mask[FLAG_N] = 1'b1;
      end
      OP_AND:  begin result = a & b;                    wr_en = 1'b1; end
      OP_OR:   begin result = a | b;                    wr_en = 1'b1; end
      OP_XOR:  begin result = a ^ b;                    wr_en = 1'b1; end
      OP_NOT:  begin result = ~b;                       wr_en = 1'b1; end
      OP_LSH:  begin result = a << shamt;               wr_en = 1'b1; end
      OP_RSH:  begin result = a >> shamt;               wr_en = 1'b1; end
      OP_ARSH: begin result = $signed(a) >>> shamt;     wr_en = 1'b1; end
      OP_MOV:  begin result = b;                        wr_en = 1'b1; end
      OP_LUI:  begin result = {b[7:0], 8'h00};          wr_en = 1'b1; end
      OP_NOP:  ;
      default: ;
    endcase

    // Every writing op refreshes Z and N from its result.
    if (wr_en) begin
      flags_next[FLAG_Z] = (result == '0);
      flags_next[FLAG_N] = result[DATA_W-1];
      flags_mask[FLAG_Z] = 1'b1;
      flags_mask[FLAG_N] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_alu.sv
// 16 x 16-bit register file with a two-operand ALU: each enabled edge performs
// Rdest <= Rdest OP (Rsrc or Imm) and updates the masked bits of the flag register.
module regfile_alu
  import regfile_alu_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic [ADDR_W-1:0] RdestRegLoc,
  input  logic [ADDR_W-1:0] RsrcRegLoc,
  input  logic [DATA_W-1:0] Imm,
  input  logic              Imm_s,
  input  logic [4:0]        OpCode,
  output logic [DATA_W-1:0] RdestOut,
  output logic [FLAG_W-1:0] Flags
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_wr_en;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] alu_mask;

  assign op_a     = regs[RdestRegLoc];
  assign op_b     = Imm_s ? Imm : regs[RsrcRegLoc];
  assign RdestOut = regs[RdestRegLoc];

  alu_core u_alu_core (
    .a          (op_a),
    .b          (op_b),
    .op_code    (OpCode),
    .c_in       (Flags[FLAG_C]),
    .result     (alu_result),
    .wr_en      (alu_wr_en),
    .flags_next (alu_flags),
    .flags_mask (alu_mask)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (En && alu_wr_en) begin
      regs[RdestRegLoc] <= alu_result;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Flags <= '0;
    end else if (En) begin
      Flags <= (Flags & ~alu_mask) | (alu_flags & alu_mask);
    end
  end

endmodule

// File: tb/tb_regfile_alu.sv
// Directed-vector bench for regfile_alu with hand-computed expected values.
module tb_regfile_alu;
  import regfile_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [15:0] imm;
  logic        imm_s;
  logic [4:0]  op;
  logic [15:0] rd_out;
  logic [4:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_alu dut (
    .Clk         (clk),
    .Rst         (rst_n),
    .En          (en),
    .RdestRegLoc (rd),
    .RsrcRegLoc  (rs),
    .Imm         (imm),
    .Imm_s       (imm_s),
    .OpCode      (op),
    .RdestOut    (rd_out),
    .Flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation at the falling edge, clock it, settle 1ns after the rising edge.
  task automatic do_op(input logic [4:0] o, input logic [3:0] d, input logic [3:0] s,
                       input logic [15:0] i, input logic is, input logic e);
    @(negedge clk);
    op = o; rd = d; rs = s; imm = i; imm_s = is; en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [3:0] d);
    rd = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rd = '0; rs = '0; imm = '0; imm_s = 1'b0; op = OP_NOP;
    #12;
    for (int r = 0; r < 16; r++) begin
      sel(r[3:0]);
      chk($sformatf("reset_r%0d", r), rd_out, 16'h0000);
    end
    chk("reset_flags", {11'b0, flags}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(OP_MOV, 4'd1, 4'd0, 16'h1234, 1'b1, 1'b1);
    chk("mov_r1", rd_out, 16'h1234);

    // No bypass: old value visible before the edge.
    @(negedge clk);
    op = OP_ADD; rd = 4'd1; imm = 16'h0001; imm_s = 1'b1; en = 1'b1;
    #1;
    chk("add_r1_pre_edge", rd_out, 16'h1234);
    @(posedge clk); #1;
    chk("add_r1", rd_out, 16'h1235);
    chk("add_r1_flags", {11'b0, flags}, 16'h0000);

    do_op(OP_MOV, 4'd2, 4'd0, 16'h7FFF, 1'b1, 1'b1);
    do_op(OP_ADD, 4'd2, 4'd0, 16'h0001, 1'b1, 1'b1);
    chk("add_ovf_r2", rd_out, 16'h8000);
    chk("add_ovf_flags", {11'b0, flags}, 16'h0005);

    do_op(OP_MOV, 4'd3, 4'd0, 16'hFFFF, 1'b1, 1'b1);
    do_op(OP_ADD, 4'd3, 4'd0, 16'h0001, 1'b1, 1'b1);
    chk("add_carry_r3", rd_out, 16'h0000);
    chk("add_carry_flags", {11'b0, flags}, 16'h0012);

    do_op(OP_ADDC, 4'd4, 4'd0, 16'h0000, 1'b1, 1'b1);
    chk("addc_r4", rd_out, 16'h0001);
    chk("addc_flags", {11'b0, flags}, 16'h0000);

    do_op(OP_MOV, 4'd5, 4'd0, 16'h0003, 1'b1, 1'b1);
    do_op(OP_MOV, 4'd6, 4'd0, 16'h0005, 1'b1, 1'b1);
    do_op(OP_CMP, 4'd5, 4'd6, 16'h0000, 1'b0, 1'b1);
    chk("cmp_r5_kept", rd_out, 16'h0003);
    chk("cmp_flags", {11'b0, flags}, 16'h0009);

    do_op(OP_SUB, 4'd5, 4'd6, 16'h0000, 1'b0, 1'b1);
    chk("sub_r5", rd_out, 16'hFFFE);
    chk("sub_flags", {11'b0, flags}, 16'h0019);

    do_op(OP_ADD, 4'd6, 4'd6, 16'h0000, 1'b0, 1'b1);
    chk("add_self_r6", rd_out, 16'h000A);
    chk("add_self_flags", {11'b0, flags}, 16'h0008);

    do_op(OP_ADD, 4'd5, 4'd0, 16'h0001, 1'b1, 1'b0);
    chk("en0_r5", rd_out, 16'hFFFE);
    chk("en0_flags", {11'b0, flags}, 16'h0008);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_r5", rd_out, 16'h0000);
    chk("async_rst_flags", {11'b0, flags}, 16'h0000);
    sel(4'd1);
    chk("async_rst_r1", rd_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(OP_MOV, 4'd7, 4'd0, 16'h00F0, 1'b1, 1'b1);
    do_op(OP_XOR, 4'd7, 4'd0, 16'h00FF, 1'b1, 1'b1);
    chk("xor_r7", rd_out, 16'h000F);
    chk("xor_flags", {11'b0, flags}, 16'h0000);
    do_op(OP_LSH, 4'd7, 4'd0, 16'h0004, 1'b1, 1'b1);
    chk("lsh_r7", rd_out, 16'h00F0);
    do_op(OP_LSH, 4'd7, 4'd0, 16'h0010, 1'b1, 1'b1);
    chk("lsh_zero_r7", rd_out, 16'h00F0);
    do_op(OP_RSH, 4'd7, 4'd0, 16'h0004, 1'b1, 1'b1);
    chk("rsh_r7", rd_out, 16'h000F);

    do_op(OP_MOV, 4'd8, 4'd0, 16'h8000, 1'b1, 1'b1);
    do_op(OP_ARSH, 4'd8, 4'd0, 16'h000F, 1'b1, 1'b1);
    chk("arsh_r8", rd_out, 16'hFFFF);
    chk("arsh_flags", {11'b0, flags}, 16'h0001);

    do_op(OP_LUI, 4'd9, 4'd0, 16'h00AB, 1'b1, 1'b1);
    chk("lui_r9", rd_out, 16'hAB00);
    do_op(OP_NOT, 4'd10, 4'd9, 16'h0000, 1'b0, 1'b1);
    chk("not_r10", rd_out, 16'h54FF);
    chk("not_flags", {11'b0, flags}, 16'h0000);

    do_op(5'h1E, 4'd9, 4'd0, 16'h1234, 1'b1, 1'b1);
    chk("unused_op_r9", rd_out, 16'hAB00);
    chk("unused_op_flags", {11'b0, flags}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
